shift_add_mult: RTL and testbench



---
 rtl/mult_pkg.sv | 13 +
 rtl/add_nbit.sv | 26 ++
 rtl/shift_add_mult.sv | 93 +++++++++
 tb/tb_shift_add_mult.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier.
// This file holds the FSM state encodings and the default operand width.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : mult_pkg

// File: rtl/add_nbit.sv
// Combinational WIDTH-bit ripple-carry adder.
// It produces the partial-product sum and carry-out for the multiplier.
module add_nbit
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]         = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i + 1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign cout = w_carry[WIDTH];

endmodule : add_nbit

// File: rtl/shift_add_mult.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier with valid/ready handshakes.
// Each CALC cycle adds one conditional partial product and shifts the accumulator right.
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_last;

    assign w_addend  = r_acc_lo[0] ? r_mcand : '0;
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign product   = {r_acc_hi, r_acc_lo};

    add_nbit #(
        .WIDTH (WIDTH)
    ) u_add (
        .a    (r_acc_hi),
        .b    (w_addend),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_next_state = ST_CALC;
            ST_CALC: if (w_last)    w_next_state = ST_DONE;
            ST_DONE: if (out_ready) w_next_state = ST_IDLE;
            default:                w_next_state = ST_IDLE;
        endcase
    end

    // The adder carry-out becomes the new accumulator MSB so no product bit is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= a;
                        r_acc_hi <= '0;
                        r_acc_lo <= b;
                        r_cnt    <= '0;
                    end
                end
                ST_CALC: begin
                    {r_acc_hi, r_acc_lo} <= {w_cout, w_sum, r_acc_lo[WIDTH-1:1]};
                    r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule : shift_add_mult

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult: directed scenarios plus a full operand sweep
// with random gaps and random backpressure, compared against plain a*b arithmetic.
module tb_shift_add_mult;

    localparam int WIDTH = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   a = '0;
    logic [WIDTH-1:0]   b = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [2*WIDTH-1:0] product;

    int checks   = 0;
    int failures = 0;

    shift_add_mult #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    // Advance past one rising edge; sampling and driving then happen 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== '0) begin
                failures++;
                $display("[TB] FAIL reset_idle cycle %0d: in_ready=%b out_valid=%b product=%h, required 1 0 00",
                         i, in_ready, out_valid, product);
            end
            step();
        end
    endtask

    task automatic test_max();
        out_ready = 1'b1;
        a = 4'd15;
        b = 4'd15;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= WIDTH; k++) begin
            step();
            checks++;
            if (out_valid !== (k == WIDTH) || in_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL max_latency edge T+%0d: out_valid=%b in_ready=%b, required %b 0",
                         k, out_valid, in_ready, (k == WIDTH));
            end
        end
        checks++;
        if (product !== 8'hE1) begin
            failures++;
            $display("[TB] FAIL max_product: got %h, required e1", product);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL max_pulse: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        a = 4'd13;
        b = 4'd11;
        in_valid = 1'b1;
        step();
        // Operands change during CALC while in_valid stays high; both must be ignored.
        a = 4'd0;
        b = 4'd9;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 6) in_valid = 1'b0;
            if (k < 4 || (k > 6 && k < 10)) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL b2b_busy edge T+%0d: in_ready=%b out_valid=%b, required 0 0",
                             k, in_ready, out_valid);
                end
            end else if (k == 4) begin
                checks++;
                if (out_valid !== 1'b1 || product !== 8'h8F) begin
                    failures++;
                    $display("[TB] FAIL b2b_first edge T+4: out_valid=%b product=%h, required 1 8f",
                             out_valid, product);
                end
            end else if (k == 5) begin
                checks++;
                if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL b2b_idle edge T+5: in_ready=%b out_valid=%b, required 1 0",
                             in_ready, out_valid);
                end
            end else if (k == 6) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL b2b_second_accept edge T+6: in_ready=%b, required 0", in_ready);
                end
            end else begin
                checks++;
                if (out_valid !== 1'b1 || product !== 8'h00) begin
                    failures++;
                    $display("[TB] FAIL b2b_second edge T+10: out_valid=%b product=%h, required 1 00",
                             out_valid, product);
                end
            end
        end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        a = 4'd7;
        b = 4'd6;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < WIDTH; k++) step();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b1 || product !== 8'h2A) begin
                failures++;
                $display("[TB] FAIL bp_hold cycle %0d: out_valid=%b product=%h, required 1 2a",
                         i, out_valid, product);
            end
            if (i < 5) step();
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 8'h2A) begin
            failures++;
            $display("[TB] FAIL bp_release: out_valid=%b in_ready=%b product=%h, required 0 1 2a",
                     out_valid, in_ready, product);
        end
    endtask

    task automatic test_reset_mid();
        int cycles;
        out_ready = 1'b1;
        a = 4'd9;
        b = 4'd9;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== '0) begin
            failures++;
            $display("[TB] FAIL abort_state: in_ready=%b out_valid=%b product=%h, required 1 0 00",
                     in_ready, out_valid, product);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL abort_no_valid cycle %0d: out_valid=%b, required 0", i, out_valid);
            end
        end
        // Reset and in_valid together: nothing may be accepted.
        rst = 1'b1;
        in_valid = 1'b1;
        a = 4'd5;
        b = 4'd5;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || product !== '0) begin
            failures++;
            $display("[TB] FAIL rst_wins: in_ready=%b product=%h, required 1 00", in_ready, product);
        end
        a = 4'd3;
        b = 4'd5;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 20) begin
            step();
            cycles++;
        end
        checks++;
        if (out_valid !== 1'b1 || product !== 8'h0F) begin
            failures++;
            $display("[TB] FAIL post_abort: out_valid=%b product=%h, required 1 0f", out_valid, product);
        end
        step();
    endtask

    task automatic test_sweep();
        int accepted;
        int handshakes;
        int cycles;
        int stall;
        int gap;
        logic [2*WIDTH-1:0] expected;
        accepted   = 0;
        handshakes = 0;
        for (int ia = 0; ia < (1 << WIDTH); ia++) begin
            for (int ib = 0; ib < (1 << WIDTH); ib++) begin
                gap = int'($urandom_range(0, 2));
                for (int g = 0; g < gap; g++) step();
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL sweep_ready a=%0d b=%0d: in_ready=%b, required 1", ia, ib, in_ready);
                end
                a = WIDTH'(ia);
                b = WIDTH'(ib);
                expected = (2 * WIDTH)'(ia * ib);
                in_valid = 1'b1;
                step();
                in_valid = 1'b0;
                accepted++;
                cycles = 0;
                while (out_valid !== 1'b1 && cycles < 3 * WIDTH) begin
                    out_ready = 1'($urandom_range(0, 1));
                    step();
                    cycles++;
                end
                checks++;
                if (out_valid !== 1'b1 || cycles != WIDTH || product !== expected) begin
                    failures++;
                    $display("[TB] FAIL sweep_product a=%0d b=%0d: out_valid=%b latency=%0d product=%h, required 1 %0d %h",
                             ia, ib, out_valid, cycles, product, WIDTH, expected);
                end
                stall = 0;
                out_ready = 1'($urandom_range(0, 1));
                while (out_ready !== 1'b1 && stall < 8) begin
                    step();
                    stall++;
                    checks++;
                    if (out_valid !== 1'b1 || product !== expected) begin
                        failures++;
                        $display("[TB] FAIL sweep_hold a=%0d b=%0d: out_valid=%b product=%h, required 1 %h",
                                 ia, ib, out_valid, product, expected);
                    end
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
                if (out_valid === 1'b1) handshakes++;
                step();
            end
        end
        checks++;
        if (handshakes != accepted) begin
            failures++;
            $display("[TB] FAIL sweep_count: handshakes=%0d, required %0d", handshakes, accepted);
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_shift_add_mult
